// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: op codes, FSM states, default width.
package muldiv_pkg;

    localparam int W_DEF = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MUL       = 3'd1,
        S_DIV_SEND  = 3'd2,
        S_DIV_WAIT  = 3'd3,
        S_DIV_DRAIN = 3'd4
    } state_e;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-stage request, HI/LO result and external divider stream signals of the HI/LO controller.
interface muldiv_hilo_ctrl_if
    import muldiv_pkg::*;
#(
    parameter int W = W_DEF
);
    logic           req_valid;
    logic [2:0]     req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic           flush;
    logic           stall;
    logic           busy;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           div_s_valid;
    logic           div_s_ready;
    logic           div_signed;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_m_valid;
    logic [2*W-1:0] div_m_data;

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush,
        input  div_s_ready, div_m_valid, div_m_data,
        output stall, busy, hi, lo,
        output div_s_valid, div_signed, div_dividend, div_divisor
    );

    modport master (
        output req_valid, req_op, req_a, req_b, flush,
        output div_s_ready, div_m_valid, div_m_data,
        input  stall, busy, hi, lo,
        input  div_s_valid, div_signed, div_dividend, div_divisor
    );
endinterface

// File: rtl/muldiv_hilo_ctrl_chk.sv
// Protocol checker: a divider result may only show up in IDLE/MUL if a divide is still outstanding.
module muldiv_hilo_ctrl_chk
    import muldiv_pkg::*;
(
    input logic   aclk,
    input state_e i_state,
    input logic   i_div_hs,
    input logic   i_m_valid
);
    // Deliberately not reset: a divide issued before a reset may still deliver its result.
    logic r_outstanding = 1'b0;

    // Track whether the divider owes a result.
    always_ff @(posedge aclk) begin
        if (i_div_hs) begin
            r_outstanding <= 1'b1;
        end else if (i_m_valid) begin
            r_outstanding <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding;
        end
    end

    a_no_stray_result: assert property (@(posedge aclk)
        (i_m_valid && ((i_state == S_IDLE) || (i_state == S_MUL))) |-> r_outstanding)
        else $error("stray divider result with no divide outstanding");
endmodule

// File: rtl/muldiv_mult.sv
// W x W -> 2W combinational multiplier; signed mode sign-extends both operands first.
module muldiv_mult #(
    parameter int W = 32
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic           i_signed,
    output logic [2*W-1:0] o_product
);
    logic [2*W-1:0] w_a_ext;
    logic [2*W-1:0] w_b_ext;

    // Truncating the 2W x 2W product of sign-extended operands yields the exact signed result.
    assign w_a_ext   = {{W{i_signed & i_a[W-1]}}, i_a};
    assign w_b_ext   = {{W{i_signed & i_b[W-1]}}, i_b};
    assign o_product = w_a_ext * w_b_ext;
endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO, owns HI/LO and drives the external divider handshake.
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int DIVZ_SKIP = 1
) (
    input logic               aclk,
    input logic               aresetn,
    muldiv_hilo_ctrl_if.slave bus
);
    state_e         r_state;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_signed;
    logic           r_div_s_valid;
    logic [2*W-1:0] w_product;
    logic           w_divz_skip;
    logic           w_div_hs;
    logic           w_stall;

    assign w_divz_skip = (DIVZ_SKIP != 0) && (bus.req_b == {W{1'b0}});
    assign w_div_hs    = r_div_s_valid && bus.div_s_ready;

    muldiv_mult #(.W(W)) u_mult (
        .i_a       (r_a),
        .i_b       (r_b),
        .i_signed  (r_signed),
        .o_product (w_product)
    );

    // Pipeline stall: held for any request while an operation owns HI/LO, released on completion.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    w_stall = is_mul(bus.req_op) || (is_div(bus.req_op) && !w_divz_skip);
                end else begin
                    w_stall = 1'b0;
                end
            end
            S_MUL:       w_stall = 1'b0;
            S_DIV_SEND:  w_stall = bus.req_valid;
            S_DIV_WAIT:  w_stall = bus.req_valid && !bus.div_m_valid;
            S_DIV_DRAIN: w_stall = bus.req_valid;
            default:     w_stall = 1'b0;
        endcase
    end

    // Controller FSM with HI/LO, latched operands and divider request valid.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_state       <= S_IDLE;
            r_hi          <= {W{1'b0}};
            r_lo          <= {W{1'b0}};
            r_a           <= {W{1'b0}};
            r_b           <= {W{1'b0}};
            r_signed      <= 1'b0;
            r_div_s_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && !bus.flush) begin
                        case (bus.req_op)
                            OP_MTHI: r_hi <= bus.req_a;
                            OP_MTLO: r_lo <= bus.req_a;
                            OP_MULT, OP_MULTU: begin
                                r_a      <= bus.req_a;
                                r_b      <= bus.req_b;
                                r_signed <= (bus.req_op == OP_MULT);
                                r_state  <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (!w_divz_skip) begin
                                    r_a           <= bus.req_a;
                                    r_b           <= bus.req_b;
                                    r_signed      <= (bus.req_op == OP_DIV);
                                    r_div_s_valid <= 1'b1;
                                    r_state       <= S_DIV_SEND;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (!bus.flush) begin
                        {r_hi, r_lo} <= w_product;
                    end else begin
                        r_state <= S_IDLE;
                    end
                    r_state <= S_IDLE;
                end
                S_DIV_SEND: begin
                    // A flush racing the handshake still leaves a result to drain.
                    if (w_div_hs) begin
                        r_div_s_valid <= 1'b0;
                        r_state       <= bus.flush ? S_DIV_DRAIN : S_DIV_WAIT;
                    end else if (bus.flush) begin
                        r_div_s_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_state <= S_DIV_SEND;
                    end
                end
                S_DIV_WAIT: begin
                    if (bus.div_m_valid) begin
                        if (!bus.flush) begin
                            r_hi <= bus.div_m_data[2*W-1:W];
                            r_lo <= bus.div_m_data[W-1:0];
                        end else begin
                            r_state <= S_IDLE;
                        end
                        r_state <= S_IDLE;
                    end else if (bus.flush) begin
                        r_state <= S_DIV_DRAIN;
                    end else begin
                        r_state <= S_DIV_WAIT;
                    end
                end
                S_DIV_DRAIN: begin
                    if (bus.div_m_valid) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DIV_DRAIN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stall        = w_stall;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.hi           = r_hi;
    assign bus.lo           = r_lo;
    assign bus.div_s_valid  = r_div_s_valid;
    assign bus.div_signed   = r_signed;
    assign bus.div_dividend = r_a;
    assign bus.div_divisor  = r_b;

    muldiv_hilo_ctrl_chk u_chk (
        .aclk      (aclk),
        .i_state   (r_state),
        .i_div_hs  (w_div_hs),
        .i_m_valid (bus.div_m_valid)
    );
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: table of single-issue ops plus divide/flush/reset sequences.
module tb_muldiv_hilo_ctrl;
    import muldiv_pkg::*;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    muldiv_hilo_ctrl_if #(.W(32)) bus ();

    muldiv_hilo_ctrl #(.W(32), .DIVZ_SKIP(1)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_stall;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
    endtask

    initial begin
        int cnt;
        vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{OP_MTHI,  32'h1234_5678, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'hFFFF_FFFA};
        vecs[3] = '{OP_MTLO,  32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'hA5A5_A5A5};
        vecs[4] = '{OP_DIV,   32'h0000_0005, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'hA5A5_A5A5};
        vecs[5] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[7] = '{OP_MULT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[8] = '{OP_DIVU,  32'h0000_0009, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[9] = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};

        bus.req_valid   = 1'b0;
        bus.req_op      = 3'd0;
        bus.req_a       = 32'd0;
        bus.req_b       = 32'd0;
        bus.flush       = 1'b0;
        bus.div_s_ready = 1'b0;
        bus.div_m_valid = 1'b0;
        bus.div_m_data  = 64'd0;
        aresetn         = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        check("reset hi", bus.hi, 64'd0);
        check("reset lo", bus.lo, 64'd0);
        check("reset busy", bus.busy, 64'd0);
        check("reset stall", bus.stall, 64'd0);
        check("reset s_valid", bus.div_s_valid, 64'd0);

        // Table: one instruction per entry, held until the pipeline is released.
        for (int i = 0; i < 10; i++) begin
            req(vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            check($sformatf("v%0d stall", i), bus.stall, vecs[i].exp_stall);
            if (vecs[i].exp_stall) begin
                step();
                check($sformatf("v%0d mul busy", i), bus.busy, 64'd1);
                check($sformatf("v%0d mul stall", i), bus.stall, 64'd0);
            end
            step();
            bus.req_valid = 1'b0;
            #1;
            check($sformatf("v%0d hi", i), bus.hi, vecs[i].exp_hi);
            check($sformatf("v%0d lo", i), bus.lo, vecs[i].exp_lo);
            check($sformatf("v%0d s_valid", i), bus.div_s_valid, 64'd0);
            check($sformatf("v%0d busy", i), bus.busy, 64'd0);
        end

        // Flush beats a request in IDLE.
        req(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        bus.flush = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("idle flush hi", bus.hi, 64'hFFFF_FFFF);

        // Signed divide with a slow-accepting divider and a long latency.
        bus.div_s_ready = 1'b0;
        req(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        #1;
        check("div accept stall", bus.stall, 64'd1);
        step();
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.div_s_valid && bus.stall && bus.div_signed) cnt++;
            step();
        end
        check("div send hold", cnt, 64'd3);
        bus.div_s_ready = 1'b1;
        #1;
        check("div s_valid", bus.div_s_valid, 64'd1);
        check("div dividend", bus.div_dividend, 64'hFFFF_FFF9);
        check("div divisor", bus.div_divisor, 64'h0000_0002);
        step();
        bus.div_s_ready = 1'b0;
        check("div s_valid drop", bus.div_s_valid, 64'd0);
        cnt = 0;
        for (int k = 0; k < 33; k++) begin
            if (bus.stall) cnt++;
            step();
        end
        check("div wait stall", cnt, 64'd33);
        bus.div_m_valid = 1'b1;
        bus.div_m_data  = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        #1;
        check("div done stall", bus.stall, 64'd0);
        step();
        bus.div_m_valid = 1'b0;
        bus.req_valid   = 1'b0;
        #1;
        check("div hi", bus.hi, 64'hFFFF_FFFF);
        check("div lo", bus.lo, 64'hFFFF_FFFD);
        check("div busy", bus.busy, 64'd0);

        // Unsigned divide flushed mid-flight; a following MTLO must wait out the drain.
        bus.div_s_ready = 1'b1;
        req(OP_DIVU, 32'd100, 32'd7);
        step();
        check("divu signed", bus.div_signed, 64'd0);
        step();
        repeat (4) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        req(OP_MTLO, 32'h0000_0055, 32'd0);
        #1;
        check("drain busy", bus.busy, 64'd1);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.stall) cnt++;
            step();
        end
        check("drain stall", cnt, 64'd5);
        bus.div_m_valid = 1'b1;
        bus.div_m_data  = {32'd2, 32'd14};
        #1;
        check("drain m_valid stall", bus.stall, 64'd1);
        step();
        bus.div_m_valid = 1'b0;
        #1;
        check("post drain stall", bus.stall, 64'd0);
        step();
        bus.req_valid = 1'b0;
        #1;
        check("drain hi", bus.hi, 64'hFFFF_FFFF);
        check("drain lo", bus.lo, 64'h0000_0055);

        // Flush before the divider accepts: request withdrawn, nothing written.
        bus.div_s_ready = 1'b0;
        req(OP_DIV, 32'd20, 32'd4);
        step();
        check("send s_valid", bus.div_s_valid, 64'd1);
        bus.flush = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("send flush s_valid", bus.div_s_valid, 64'd0);
        check("send flush busy", bus.busy, 64'd0);
        check("send flush lo", bus.lo, 64'h0000_0055);

        // Flush during MUL suppresses the write.
        req(OP_MULT, 32'd2, 32'd3);
        step();
        bus.flush = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("mul flush hi", bus.hi, 64'hFFFF_FFFF);
        check("mul flush lo", bus.lo, 64'h0000_0055);

        // Reset in DIV_WAIT, then the old divide's result shows up late.
        bus.div_s_ready = 1'b1;
        req(OP_DIV, 32'd10, 32'd3);
        step();
        step();
        step();
        #2;
        aresetn       = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        check("rst busy", bus.busy, 64'd0);
        check("rst hi", bus.hi, 64'd0);
        check("rst lo", bus.lo, 64'd0);
        check("rst s_valid", bus.div_s_valid, 64'd0);
        check("rst stall", bus.stall, 64'd0);
        #1;
        aresetn = 1'b0;
        step();
        bus.div_m_valid = 1'b1;
        bus.div_m_data  = {32'd1, 32'd3};
        step();
        bus.div_m_valid = 1'b0;
        #1;
        check("stray hi", bus.hi, 64'd0);
        check("stray lo", bus.lo, 64'd0);
        check("stray busy", bus.busy, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
